led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
- Parametrised successor to the single-pair 8x8 LED multiplexer.
- Drives NUM_PANELS column-multiplexed LED matrices that share one row bus.
- Holds a double-buffered frame store, written one column at a time from an upstream byte source (e.g. the SPI receiver).
- Adds programmable dwell and blanking (anti-ghosting), frame-synchronous buffer swap, and a scan enable.

Parameters:
- NUM_PANELS, 2, number of matrices sharing the row bus.
- COLS, 8, columns per panel.
- ROWS, 8, rows per column (row bus width).
- DWELL_CYCLES, 16384, clk cycles each column is driven; must be >= 1.
- BLANK_CYCLES, 4, clk cycles of all-off between columns; 0 disables blanking.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  scan enable
- wr_en  in  1  write strobe into back buffer
- wr_panel  in  $clog2(NUM_PANELS)  target panel
- wr_col  in  $clog2(COLS)  target column
- wr_data  in  ROWS  column pattern; bit=0 LED on, bit=1 LED off
- swap_req  in  1  request back/front swap at next frame boundary
- swap_ack  out  1  one-cycle pulse when swap commits
- frame_done  out  1  one-cycle pulse at end of last column of last panel
- row  out  ROWS  row drive, active-low (1 = off)
- col_en  out  NUM_PANELS*COLS  one-hot column enable; index = panel*COLS+col

Behaviour:
- Reset (reset==0 at clk edge), synchronous, active-low:
  - state=S_IDLE; panel=0; col=0; counter=0; swap pending cleared; front buffer = buffer 0.
  - Both buffers cleared to all ones (blank).
  - Outputs: row='1, col_en=0, swap_ack=0, frame_done=0.
  - Reset mid-scan behaves identically.
- States:
  - S_IDLE: row='1, col_en=0. On enable=1, go to S_BLANK (or S_DRIVE if BLANK_CYCLES=0) with panel=0, col=0, counter=0.
  - S_BLANK: row='1, col_en=0 for exactly BLANK_CYCLES cycles, then S_DRIVE.
  - S_DRIVE: row=front[panel][col], col_en one-hot at panel*COLS+col, for exactly DWELL_CYCLES cycles. Then advance col; on col wrap, advance panel; on panel wrap, back to 0. Next state is S_BLANK (or S_DRIVE if BLANK_CYCLES=0).
- Outputs are registered: values reflect the current state. No combinational path from inputs to row or col_en.
- frame_done pulses in the last S_DRIVE cycle of panel NUM_PANELS-1, col COLS-1.
- Full frame period = NUM_PANELS*COLS*(DWELL_CYCLES+BLANK_CYCLES) cycles.
- enable deasserted in any state: S_IDLE on the next edge; position resets to 0,0. No frame_done is issued.
- Writes:
  - wr_en=1 writes wr_data to back[wr_panel][wr_col] at the edge.
  - Out-of-range indices (non-power-of-2 params) are ignored.
  - Writes never touch the front buffer.
- Swap:
  - swap_req=1 sets pending. Repeat requests while pending have no additional effect.
  - Pending commits at the frame_done edge. If in S_IDLE, it commits on the edge after it is set.
  - On commit: front/back select toggles, pending clears, swap_ack=1 for one cycle (the cycle after commit).
  - New content is shown from the next panel 0, col 0 onward.
  - After a swap the back buffer holds the previous front frame; there is no copy.
- Simultaneous events:
  - wr_en on the commit edge: the write lands in the pre-swap back buffer, which becomes the front buffer. The write is therefore visible.
  - swap_req on the commit edge: that request is consumed by this commit and does not re-arm pending.
- Counter width: $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); it wraps to 0 on every state change.

Decomposition:
- Package led_scan_pkg:
  - scan_state_t enum {S_IDLE, S_BLANK, S_DRIVE}.
  - Constant ROW_OFF (all ones).
  - Function for one-hot column index.
- Sub-module led_frame_buffer:
  - Two NUM_PANELS*COLS x ROWS register arrays plus front-select bit.
  - Write port to back buffer, read port from front buffer.
  - swap input; reset clear.
- led_scan_ctrl holds the FSM, counters, and swap/pending logic.

Test Plan:
All scenarios use NUM_PANELS=2, COLS=8, ROWS=8, DWELL=4, BLANK=2 unless stated.
1. Reset, then enable=1 -> 2 cycles col_en=0 and row=8'hFF, then 4 cycles col_en=16'h0001 and row=8'hFF; frame_done exactly every 96 cycles.
2. Write back[1][3]=8'h5A, swap_req=1, wait for frame_done -> swap_ack pulses next cycle; on the next frame, during col_en=16'h0800, row=8'h5A; all other columns show 8'hFF.
3. swap_req on 3 cycles within one frame -> exactly one swap_ack at the frame boundary; no swap at the following frame.
4. wr_en to [0][0]=8'h00 on the commit edge -> next frame shows row=8'h00 under col_en=16'h0001.
5. enable dropped mid S_DRIVE of panel 1, col 2 -> next cycle col_en=0 and row=FF; re-enable restarts at col_en=16'h0001 after 2 blank cycles.
6. BLANK_CYCLES=0 variant, and a reset pulse mid-frame -> no blank gaps, period 64 cycles; reset returns all outputs to idle values and the frame shows blank after re-enable.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the multi-panel LED column scanner.
package led_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } scan_state_t;

    // Row bus "all LEDs off" pattern; sliced down to the actual row width.
    localparam int ROW_MAX_W = 64;
    localparam logic [ROW_MAX_W-1:0] ROW_OFF = '1;

    // Flat column index into the one-hot enable vector / frame store.
    function automatic int unsigned col_index(input int unsigned panel,
                                              input int unsigned col,
                                              input int unsigned cols);
        return panel * cols + col;
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered column store: writes go to the back buffer, reads come
// from the front buffer, and a swap flips which physical array is front.
module led_frame_buffer
    import led_scan_pkg::*;
#(
    parameter int NUM_PANELS = 2,
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    localparam int PW        = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1,
    localparam int CLW       = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en_i,
    input  logic [PW-1:0]   wr_panel_i,
    input  logic [CLW-1:0]  wr_col_i,
    input  logic [ROWS-1:0] wr_data_i,
    input  logic            swap_i,
    input  logic [PW-1:0]   rd_panel_i,
    input  logic [CLW-1:0]  rd_col_i,
    output logic [ROWS-1:0] rd_data_o
);

    localparam int NCELLS = NUM_PANELS * COLS;
    localparam int IW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [ROWS-1:0] OFF = ROW_OFF[ROWS-1:0];

    logic [ROWS-1:0] mem_q [2][NCELLS];
    logic            front_q;
    logic            wr_ok;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;

    // Indices beyond the panel/column count are dropped rather than aliased.
    assign wr_ok  = (32'(wr_panel_i) < 32'(NUM_PANELS)) && (32'(wr_col_i) < 32'(COLS));
    assign wr_idx = IW'(col_index(32'(wr_panel_i), 32'(wr_col_i), COLS));
    assign rd_idx = IW'(col_index(32'(rd_panel_i), 32'(rd_col_i), COLS));

    assign rd_data_o = mem_q[front_q][rd_idx];

    // Front-select bit; the swap is the only thing that moves it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            front_q <= 1'b0;
        end else if (swap_i) begin
            front_q <= ~front_q;
        end
    end

    // Storage: reset blanks both buffers; writes use the pre-swap back side,
    // so a write on the swap edge ends up in the new front buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCELLS; i++) begin
                mem_q[0][IW'(i)] <= OFF;
                mem_q[1][IW'(i)] <= OFF;
            end
        end else if (wr_en_i && wr_ok) begin
            mem_q[~front_q][wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Column scanner for NUM_PANELS LED matrices sharing one active-low row bus,
// with dwell/blank timing and frame-synchronous buffer swap.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int NUM_PANELS   = 2,
    parameter int COLS         = 8,
    parameter int ROWS         = 8,
    parameter int DWELL_CYCLES = 16384,
    parameter int BLANK_CYCLES = 4,
    localparam int PW          = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1,
    localparam int CLW         = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NCOL        = NUM_PANELS * COLS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            wr_en,
    input  logic [PW-1:0]   wr_panel,
    input  logic [CLW-1:0]  wr_col,
    input  logic [ROWS-1:0] wr_data,
    input  logic            swap_req,
    output logic            swap_ack,
    output logic            frame_done,
    output logic [ROWS-1:0] row,
    output logic [NCOL-1:0] col_en
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL_CYCLES - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [PW-1:0]   LAST_PANEL = PW'(NUM_PANELS - 1);
    localparam logic [CLW-1:0]  LAST_COL   = CLW'(COLS - 1);
    // With blanking disabled, columns run back to back.
    localparam scan_state_t     AFTER_COL  = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

    scan_state_t     state_q, state_d;
    logic [PW-1:0]   panel_q, panel_d;
    logic [CLW-1:0]  col_q, col_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic            ack_q;
    logic            commit;
    logic [ROWS-1:0] front_row;

    // Last dwell cycle of the last column; an aborted scan never reports it.
    assign frame_done = enable && (state_q == S_DRIVE) && (panel_q == LAST_PANEL)
                        && (col_q == LAST_COL) && (cnt_q == DWELL_LAST);

    // A pending swap lands at the frame boundary, or immediately while idle.
    assign commit   = pending_q && (frame_done || (state_q == S_IDLE));
    assign swap_ack = ack_q;

    assign row    = (state_q == S_DRIVE) ? front_row : ROW_OFF[ROWS-1:0];
    assign col_en = (state_q == S_DRIVE)
                    ? (NCOL'(1) << col_index(32'(panel_q), 32'(col_q), COLS))
                    : '0;

    led_frame_buffer #(
        .NUM_PANELS (NUM_PANELS),
        .COLS       (COLS),
        .ROWS       (ROWS)
    ) u_fb (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_panel_i (wr_panel),
        .wr_col_i   (wr_col),
        .wr_data_i  (wr_data),
        .swap_i     (commit),
        .rd_panel_i (panel_q),
        .rd_col_i   (col_q),
        .rd_data_o  (front_row)
    );

    // Scan state, position, dwell/blank counter and swap bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            panel_q   <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            panel_q   <= panel_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ack_q     <= commit;
        end
    end

    // Next-state: blank/drive sequencing and column/panel advance.
    always_comb begin
        state_d   = state_q;
        panel_d   = panel_q;
        col_d     = col_q;
        cnt_d     = cnt_q + 1'b1;
        // A request arriving on the commit edge is absorbed by that commit.
        pending_d = commit ? 1'b0 : (pending_q | swap_req);

        if (!enable) begin
            state_d = S_IDLE;
            panel_d = '0;
            col_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = AFTER_COL;
                    panel_d = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = AFTER_COL;
                        cnt_d   = '0;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            panel_d = (panel_q == LAST_PANEL) ? '0 : panel_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    panel_d = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: one instance with blanking, one without.
module tb_led_scan_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with DWELL=4, BLANK=2.
    logic        reset, enable, wr_en, swap_req, swap_ack, frame_done;
    logic [0:0]  wr_panel;
    logic [2:0]  wr_col;
    logic [7:0]  wr_data, row;
    logic [15:0] col_en;

    // Instance with DWELL=4, BLANK=0.
    logic        reset_z, enable_z, wr_en_z, swap_req_z, swap_ack_z, frame_done_z;
    logic [0:0]  wr_panel_z;
    logic [2:0]  wr_col_z;
    logic [7:0]  wr_data_z, row_z;
    logic [15:0] col_en_z;

    led_scan_ctrl #(.NUM_PANELS(2), .COLS(8), .ROWS(8), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_panel(wr_panel),
        .wr_col(wr_col), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_done(frame_done), .row(row), .col_en(col_en)
    );

    led_scan_ctrl #(.NUM_PANELS(2), .COLS(8), .ROWS(8), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset_z), .enable(enable_z), .wr_en(wr_en_z), .wr_panel(wr_panel_z),
        .wr_col(wr_col_z), .wr_data(wr_data_z), .swap_req(swap_req_z), .swap_ack(swap_ack_z),
        .frame_done(frame_done_z), .row(row_z), .col_en(col_en_z)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic [15:0] col;
        logic [7:0]  row;
        logic        fd;
    } vec_t;
    vec_t tv [19];

    // Reference copy of the two frame buffers for the BLANK=2 instance.
    logic [7:0] front_m [16];
    logic [7:0] back_m  [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_swap();
        logic [7:0] t;
        for (int k = 0; k < 16; k++) begin
            t = front_m[k];
            front_m[k] = back_m[k];
            back_m[k] = t;
        end
    endtask

    function automatic logic [15:0] exp_col(input int i);
        if ((i % 6) < 2) return 16'h0000;
        return 16'(1) << (i / 6);
    endfunction

    function automatic logic [7:0] exp_row(input int i);
        if ((i % 6) < 2) return 8'hFF;
        return front_m[4'(i / 6)];
    endfunction

    // Steps frame positions first..95 (position 0 is the first blank cycle).
    task automatic check_frame(input string nm, input int first, input logic [95:0] reqm,
                               output int acks);
        int errs;
        errs = 0;
        acks = 0;
        for (int i = first; i < 96; i++) begin
            swap_req = reqm[7'(i)];
            step();
            if (col_en !== exp_col(i) || row !== exp_row(i) || frame_done !== (i == 95)) errs++;
            if (swap_ack === 1'b1) acks++;
        end
        swap_req = 1'b0;
        chk(nm, 32'(errs), 32'd0);
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (frame_done === 1'b1) break;
        end
    endtask

    task automatic z_run(output int n, output int zeros, output int rerr);
        n = 0; zeros = 0; rerr = 0;
        while (n < 300) begin
            step();
            n++;
            if (col_en_z === 16'h0000) zeros++;
            if (row_z !== ((col_en_z === 16'h0020) ? 8'h33 : 8'hFF)) rerr++;
            if (frame_done_z === 1'b1) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acks, zeros, rerr, k;
        logic [95:0] m;

        tv[0]  = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[1]  = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[2]  = '{1'b1, 16'h0001, 8'hFF, 1'b0};
        tv[3]  = '{1'b1, 16'h0001, 8'hFF, 1'b0};
        tv[4]  = '{1'b1, 16'h0001, 8'hFF, 1'b0};
        tv[5]  = '{1'b1, 16'h0001, 8'hFF, 1'b0};
        tv[6]  = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[7]  = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[8]  = '{1'b1, 16'h0002, 8'hFF, 1'b0};
        tv[9]  = '{1'b1, 16'h0002, 8'hFF, 1'b0};
        tv[10] = '{1'b1, 16'h0002, 8'hFF, 1'b0};
        tv[11] = '{1'b1, 16'h0002, 8'hFF, 1'b0};
        tv[12] = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[13] = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[14] = '{1'b0, 16'h0000, 8'hFF, 1'b0};
        tv[15] = '{1'b0, 16'h0000, 8'hFF, 1'b0};
        tv[16] = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[17] = '{1'b1, 16'h0000, 8'hFF, 1'b0};
        tv[18] = '{1'b1, 16'h0001, 8'hFF, 1'b0};

        for (int i = 0; i < 16; i++) begin
            front_m[i] = 8'hFF;
            back_m[i]  = 8'hFF;
        end

        reset = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_panel = '0; wr_col = '0;
        wr_data = '0; swap_req = 1'b0;
        reset_z = 1'b0; enable_z = 1'b0; wr_en_z = 1'b0; wr_panel_z = '0; wr_col_z = '0;
        wr_data_z = '0; swap_req_z = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_row", 32'(row), 32'hFF);
        chk("rst_col_en", 32'(col_en), 32'h0);
        chk("rst_ack", 32'(swap_ack), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        reset = 1'b1;
        step();

        // Start-up blank/drive pattern and an enable drop, vector by vector
        for (int i = 0; i < 19; i++) begin
            enable = tv[i].en;
            step();
            if (col_en !== tv[i].col || row !== tv[i].row || frame_done !== tv[i].fd) begin
                bad++;
                $display("FAIL vec%0d: col_en=%0h row=%0h fd=%0b expected %0h %0h %0b",
                         i, col_en, row, frame_done, tv[i].col, tv[i].row, tv[i].fd);
            end
            total++;
        end

        // Frame period
        wait_fd(n);
        chk("first_fd_latency", 32'(n), 32'd93);
        wait_fd(n);
        chk("fd_period", 32'(n), 32'd96);

        // Write back[1][3] and request a swap on the frame_done edge
        wr_en = 1'b1; wr_panel = 1'b1; wr_col = 3'd3; wr_data = 8'h5A; swap_req = 1'b1;
        step();
        wr_en = 1'b0; swap_req = 1'b0;
        back_m[11] = 8'h5A;
        chk("t2_no_early_ack", 32'(swap_ack), 32'h0);
        check_frame("t2_pre_frame", 1, '0, acks);
        chk("t2_pre_acks", 32'(acks), 32'd0);
        step();
        chk("t2_ack", 32'(swap_ack), 32'h1);
        model_swap();
        check_frame("t2_shown_frame", 1, '0, acks);
        chk("t2_ack_single", 32'(acks), 32'd0);

        // Three requests in one frame, then write + request on the commit edge
        step();
        chk("t3_no_ack_start", 32'(swap_ack), 32'h0);
        m = '0; m[10] = 1'b1; m[20] = 1'b1; m[30] = 1'b1;
        check_frame("t3_frame", 1, m, acks);
        chk("t3_acks_in_frame", 32'(acks), 32'd0);
        wr_en = 1'b1; wr_panel = 1'b0; wr_col = 3'd0; wr_data = 8'h00; swap_req = 1'b1;
        step();
        wr_en = 1'b0; swap_req = 1'b0;
        chk("t3_ack", 32'(swap_ack), 32'h1);
        back_m[0] = 8'h00;
        model_swap();
        check_frame("t4_frame", 1, '0, acks);
        chk("t4_acks", 32'(acks), 32'd0);
        step();
        chk("t3_no_rearm", 32'(swap_ack), 32'h0);

        // Drop enable while driving panel 1 column 2
        k = 0;
        while (col_en !== 16'h0400 && k < 100) begin
            step();
            k++;
        end
        chk("t5_reach_p1c2", 32'(col_en), 32'h0400);
        step();
        enable = 1'b0;
        step();
        chk("t5_off_col", 32'(col_en), 32'h0);
        chk("t5_off_row", 32'(row), 32'hFF);
        step();
        chk("t5_idle_fd", 32'(frame_done), 32'h0);
        enable = 1'b1;
        step();
        chk("t5_blank0", 32'(col_en), 32'h0);
        step();
        chk("t5_blank1", 32'(col_en), 32'h0);
        step();
        chk("t5_restart_col", 32'(col_en), 32'h0001);
        chk("t5_restart_row", 32'(row), 32'h00);

        // No-blank instance: idle swap, back-to-back columns, mid-frame reset
        reset_z = 1'b1;
        step();
        chk("z_rst_col", 32'(col_en_z), 32'h0);
        wr_en_z = 1'b1; wr_panel_z = 1'b0; wr_col_z = 3'd5; wr_data_z = 8'h33; swap_req_z = 1'b1;
        step();
        wr_en_z = 1'b0; swap_req_z = 1'b0;
        chk("z_ack_not_yet", 32'(swap_ack_z), 32'h0);
        step();
        chk("z_idle_ack", 32'(swap_ack_z), 32'h1);
        step();
        chk("z_ack_once", 32'(swap_ack_z), 32'h0);
        enable_z = 1'b1;
        step();
        chk("z_first_col", 32'(col_en_z), 32'h0001);
        chk("z_first_row", 32'(row_z), 32'hFF);
        z_run(n, zeros, rerr);
        chk("z_first_fd", 32'(n), 32'd63);
        chk("z_no_gap1", 32'(zeros), 32'd0);
        z_run(n, zeros, rerr);
        chk("z_period", 32'(n), 32'd64);
        chk("z_no_gap2", 32'(zeros), 32'd0);
        chk("z_rows", 32'(rerr), 32'd0);
        repeat (20) step();
        reset_z = 1'b0;
        enable_z = 1'b0;
        step();
        chk("z_rst_row", 32'(row_z), 32'hFF);
        chk("z_rst_col_en", 32'(col_en_z), 32'h0);
        chk("z_rst_ack", 32'(swap_ack_z), 32'h0);
        chk("z_rst_fd", 32'(frame_done_z), 32'h0);
        reset_z = 1'b1;
        step();
        enable_z = 1'b1;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (col_en_z !== (16'(1) << (i / 4)) || row_z !== 8'hFF || frame_done_z !== (i == 63)) k++;
        end
        chk("z_blank_after_reset", 32'(k), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
